// File: rtl/reg_file32.sv
// reg_file32: 2-read/1-write register file, register 0 hard-wired to zero
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding to read ports)
// Ports:
//   clk      - clock, writes commit on rising edge
//   rst      - asynchronous active-high reset, clears every register
//   rs_addr  - read port A address
//   rt_addr  - read port B address
//   rd_addr  - write address
//   wr_data  - write data
//   wr_en    - write enable
//   rs_data  - read port A data (ALU operand A)
//   rt_data  - read port B data (operand-B mux in1 / store data)
module reg_file32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);
    localparam int N = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs [N];
    logic wr_hit;
    assign wr_hit = wr_en && rd_addr != '0;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < N; i++) regs[i] <= '0;
        else if (wr_hit)
            regs[rd_addr] <= wr_data;
    // rst gates the outputs so reads are zero for the whole reset window
`ifdef REGFILE_BYPASS_EN
    assign rs_data = (rst || rs_addr == '0) ? '0 : (wr_hit && rd_addr == rs_addr) ? wr_data : regs[rs_addr];
    assign rt_data = (rst || rt_addr == '0) ? '0 : (wr_hit && rd_addr == rt_addr) ? wr_data : regs[rt_addr];
`else
    assign rs_data = (rst || rs_addr == '0) ? '0 : regs[rs_addr];
    assign rt_data = (rst || rt_addr == '0) ? '0 : regs[rt_addr];
`endif
endmodule

// File: tb/tb_reg_file32.sv
// tb_reg_file32: randomized and directed check of reg_file32 against an array model
module tb_reg_file32;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mdl [32];

    reg_file32 dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .wr_data(wr_data), .wr_en(wr_en), .rs_data(rs_data), .rt_data(rt_data)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 32; i++) mdl[i] = '0;

    always @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < 32; i++) mdl[i] <= '0;
        else if (wr_en && rd_addr != 0) mdl[rd_addr] <= wr_data;

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (rst || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && rd_addr == a) return wr_data;
`endif
        return mdl[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rs", rs_data, expect_rd(rs_addr));
        chk("model_rt", rt_data, expect_rd(rt_addr));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        rd_addr = a;
        wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        rs_addr = 5'd5;
        rt_addr = 5'd31;
        #1;
        chk("reset_rs", rs_data, 32'h0);
        chk("reset_rt", rt_data, 32'h0);
        cyc();
        rst = 1'b0;

        // 1: async reset without a clock edge
        wr(5'd5, 32'h1234_5678);
        rs_addr = 5'd5;
        #1;
        chk("t1_pre", rs_data, 32'h1234_5678);
        rst = 1'b1;
        #1;
        chk("t1_during", rs_data, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("t1_after", rs_data, 32'h0);
        cyc();

        // 2: write to r0 discarded
        wr(5'd0, 32'hFFFF_FFFF);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        chk("t2_rs", rs_data, 32'h0);
        chk("t2_rt", rt_data, 32'h0);

        // 3: consecutive writes at the address extremes
        wr(5'd1, 32'hA5A5_A5A5);
        wr(5'd31, 32'h0000_0001);
        rs_addr = 5'd1;
        rt_addr = 5'd31;
        #1;
        chk("t3_rs", rs_data, 32'hA5A5_A5A5);
        chk("t3_rt", rt_data, 32'h0000_0001);

        // 4: read of a register being written
        wr(5'd7, 32'h11);
        wr_en = 1'b1;
        rd_addr = 5'd7;
        wr_data = 32'h22;
        rs_addr = 5'd7;
        rt_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t4_pre_rs", rs_data, 32'h22);
        chk("t4_pre_rt", rt_data, 32'h22);
`else
        chk("t4_pre_rs", rs_data, 32'h11);
        chk("t4_pre_rt", rt_data, 32'h11);
`endif
        cyc();
        wr_en = 1'b0;
        #1;
        chk("t4_post_rs", rs_data, 32'h22);
        chk("t4_post_rt", rt_data, 32'h22);

        // 5: wr_en low holds state
        rd_addr = 5'd3;
        wr_data = 32'hDEAD_BEEF;
        repeat (4) cyc();
        rs_addr = 5'd3;
        #1;
        chk("t5_r3", rs_data, 32'h0);

        // 6: reset across a write edge wins
        wr_en = 1'b1;
        rd_addr = 5'd9;
        wr_data = 32'h55;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wr_en = 1'b0;
        rs_addr = 5'd9;
        #1;
        chk("t6_r9", rs_data, 32'h0);

        // random traffic, addresses biased low to provoke collisions
        repeat (600) begin
            cyc();
            rst = ($urandom_range(0, 49) == 0);
            wr_en = $urandom_range(0, 3) != 0;
            rd_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rs_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rt_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data = $urandom;
        end
        cyc();
        rst = 1'b0;
        wr_en = 1'b0;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
